// File: rtl/mc_core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Owns pc, ir, alu/mdr staging registers, trap state and performance counters.
module mc_core_ctrl #(
   parameter int unsigned       XLEN     = 32,
   parameter int unsigned       CNT_W    = 64,
   parameter logic [XLEN-1:0]   RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,

   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,

   output logic [31:0]       ir,
   input  logic              dec_wrt_en,
   input  logic              dec_mem_rd_en,
   input  logic              dec_mem_wrt_en,
   input  logic              dec_wrt_back_sel,
   input  logic              dec_branch_en,
   input  logic              dec_jump,
   input  logic              dec_link,
   input  logic              dec_illegal,
   input  logic [1:0]        dec_mem_mask,

   input  logic [XLEN-1:0]   alu_out,
   input  logic              branch_taken,

   output logic              dmem_req,
   output logic              dmem_we,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [1:0]        dmem_mask,
   input  logic              dmem_ready,
   input  logic [XLEN-1:0]   dmem_rdata,

   output logic              rf_wrt_en,
   output logic [XLEN-1:0]   wb_data,
   output logic [XLEN-1:0]   pc,
   output logic              trap,
   output logic [1:0]        trap_cause,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  instret_cnt
);

   localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
   localparam logic [1:0]  CAUSE_NONE  = 2'd0;
   localparam logic [1:0]  CAUSE_FETCH = 2'd1;
   localparam logic [1:0]  CAUSE_LDST  = 2'd2;
   localparam logic [1:0]  CAUSE_ILL   = 2'd3;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q;
   logic [31:0]       ir_q;
   logic [XLEN-1:0]   alu_q;
   logic [XLEN-1:0]   mdr_q;
   logic              we_q;
   logic [1:0]        mask_q;
   logic              trap_q;
   logic [1:0]        cause_q;
   logic [CNT_W-1:0]  cycle_q;
   logic [CNT_W-1:0]  instret_q;

   logic              ir_ld;
   logic              alu_ld;
   logic              mdr_ld;
   logic              pc_ld;
   logic              trap_ld;
   logic [1:0]        cause_d;

   logic              mem_op;
   logic              addr_misaligned;
   logic              fetch_misaligned;
   logic              pc_redirect;
   logic [XLEN-1:0]   pc_plus4;
   logic [XLEN-1:0]   pc_next;

   assign mem_op           = dec_mem_rd_en | dec_mem_wrt_en;
   assign fetch_misaligned = (pc_q[1:0] != 2'b00);
   assign pc_redirect      = dec_jump | (dec_branch_en & branch_taken);
   assign pc_plus4         = pc_q + XLEN'(4);
   assign pc_next          = pc_redirect ? alu_q : pc_plus4;

   // Natural alignment of the effective address for the requested access size
   always_comb begin
      addr_misaligned = 1'b0;
      case (dec_mem_mask)
         2'd0:    addr_misaligned = 1'b0;
         2'd1:    addr_misaligned = alu_out[0];
         default: addr_misaligned = |alu_out[1:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_FETCH;
      else      state_q <= state_d;
   end

   // Next-state and register-load strobes
   always_comb begin
      state_d = state_q;
      ir_ld   = 1'b0;
      alu_ld  = 1'b0;
      mdr_ld  = 1'b0;
      pc_ld   = 1'b0;
      trap_ld = 1'b0;
      cause_d = CAUSE_NONE;
      case (state_q)
         S_FETCH: begin
            if (fetch_misaligned) begin
               state_d = S_TRAP;
               trap_ld = 1'b1;
               cause_d = CAUSE_FETCH;
            end else if (imem_ready) begin
               ir_ld   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (dec_illegal) begin
               state_d = S_TRAP;
               trap_ld = 1'b1;
               cause_d = CAUSE_ILL;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_ld = 1'b1;
            if (mem_op && addr_misaligned) begin
               state_d = S_TRAP;
               trap_ld = 1'b1;
               cause_d = CAUSE_LDST;
            end else if (mem_op) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (dmem_ready) begin
               mdr_ld  = ~we_q;
               state_d = S_WB;
            end
         end
         S_WB: begin
            pc_ld   = 1'b1;
            state_d = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Architectural and staging registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= RESET_PC;
         ir_q    <= NOP_INSN;
         alu_q   <= '0;
         mdr_q   <= '0;
         we_q    <= 1'b0;
         mask_q  <= 2'd0;
         trap_q  <= 1'b0;
         cause_q <= CAUSE_NONE;
      end else begin
         if (ir_ld) ir_q <= imem_rdata;
         if (alu_ld) begin
            alu_q  <= alu_out;
            we_q   <= dec_mem_wrt_en;
            mask_q <= dec_mem_mask;
         end
         if (mdr_ld) mdr_q <= dmem_rdata;
         if (pc_ld)  pc_q  <= pc_next;
         if (trap_ld) begin
            trap_q  <= 1'b1;
            cause_q <= cause_d;
         end
      end
   end

   // Performance counters; cycle_cnt stops once halted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if (state_q != S_TRAP) cycle_q   <= cycle_q + CNT_W'(1);
         if (pc_ld)             instret_q <= instret_q + CNT_W'(1);
      end
   end

   // Fetch request is forced low while reset is held so an abandoned fetch is dropped
   assign imem_req    = rst & (state_q == S_FETCH) & ~fetch_misaligned;
   assign imem_addr   = pc_q;
   assign ir          = ir_q;

   assign dmem_req    = (state_q == S_MEM);
   assign dmem_we     = we_q;
   assign dmem_addr   = alu_q;
   assign dmem_mask   = mask_q;

   assign rf_wrt_en   = (state_q == S_WB) & dec_wrt_en;
   assign wb_data     = dec_link         ? pc_plus4 :
                        dec_wrt_back_sel ? mdr_q    : alu_q;

   assign pc          = pc_q;
   assign trap        = trap_q;
   assign trap_cause  = cause_q;
   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;

endmodule

// File: tb/tb_mc_core_ctrl.sv
// Bench for mc_core_ctrl: acts as memories and decoder, checks per-instruction
// behaviour against a transaction-level model of the sequencing rules.
module tb_mc_core_ctrl;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_ready;
   logic [31:0] imem_addr, imem_rdata, ir;
   logic        dec_wrt_en, dec_mem_rd_en, dec_mem_wrt_en, dec_wrt_back_sel;
   logic        dec_branch_en, dec_jump, dec_link, dec_illegal;
   logic [1:0]  dec_mem_mask;
   logic [31:0] alu_out;
   logic        branch_taken;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [31:0] dmem_addr, dmem_rdata;
   logic [1:0]  dmem_mask;
   logic        rf_wrt_en;
   logic [31:0] wb_data, pc;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [63:0] cycle_cnt, instret_cnt;

   mc_core_ctrl #(.XLEN(32), .CNT_W(64), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .ir(ir),
      .dec_wrt_en(dec_wrt_en), .dec_mem_rd_en(dec_mem_rd_en), .dec_mem_wrt_en(dec_mem_wrt_en),
      .dec_wrt_back_sel(dec_wrt_back_sel), .dec_branch_en(dec_branch_en), .dec_jump(dec_jump),
      .dec_link(dec_link), .dec_illegal(dec_illegal), .dec_mem_mask(dec_mem_mask),
      .alu_out(alu_out), .branch_taken(branch_taken),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_mask(dmem_mask),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .rf_wrt_en(rf_wrt_en), .wb_data(wb_data), .pc(pc),
      .trap(trap), .trap_cause(trap_cause),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wrt, rd, wr, sel, br, taken, jump, link, ill;
      logic [1:0]  mask;
      logic [31:0] alu, rdata, word;
      int          wi, wd, rst_at;
   } instr_t;

   int          errors = 0;
   int          checks = 0;

   // Architectural model state
   logic [31:0] m_pc;
   logic [31:0] m_ir;
   logic [31:0] m_mdr;
   logic [63:0] m_cycle;
   logic [63:0] m_instret;
   logic [1:0]  m_cause;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_pc      = RPC;
      m_ir      = 32'h0000_0013;
      m_mdr     = 32'h0;
      m_cycle   = 64'd0;
      m_instret = 64'd0;
      m_cause   = 2'd0;
   endtask

   task automatic check_reset_state();
      chk1 ("rst_imem_req", imem_req, 1'b0);
      chk1 ("rst_dmem_req", dmem_req, 1'b0);
      chk1 ("rst_rf_wrt",   rf_wrt_en, 1'b0);
      chk32("rst_pc",       pc, RPC);
      chk32("rst_ir",       ir, 32'h0000_0013);
      chk1 ("rst_trap",     trap, 1'b0);
      chk2 ("rst_cause",    trap_cause, 2'd0);
      chk64("rst_cycle",    cycle_cnt, 64'd0);
      chk64("rst_instret",  instret_cnt, 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      #1;
      check_reset_state();
      nxt();
      nxt();
      rst = 1'b1;
      model_reset();
   endtask

   function automatic instr_t base_instr();
      instr_t t;
      t.wrt = 1'b0; t.rd = 1'b0; t.wr = 1'b0; t.sel = 1'b0; t.br = 1'b0;
      t.taken = 1'b0; t.jump = 1'b0; t.link = 1'b0; t.ill = 1'b0;
      t.mask = 2'd2; t.alu = 32'h0; t.rdata = 32'h0; t.word = 32'h0000_0013;
      t.wi = 0; t.wd = 0; t.rst_at = -1;
      return t;
   endfunction

   function automatic instr_t rnd_instr();
      instr_t t;
      int     kind;
      logic [31:0] a;
      t = base_instr();
      kind = int'($urandom_range(0, 4));
      a = $urandom;
      t.mask = 2'($urandom_range(0, 2));
      if (t.mask == 2'd1) a[0] = 1'b0;
      else if (t.mask == 2'd2) a[1:0] = 2'b00;
      t.word = $urandom;
      t.rdata = $urandom;
      t.wi = int'($urandom_range(0, 3));
      t.wd = int'($urandom_range(0, 3));
      case (kind)
         0: begin t.wrt = 1'b1; t.alu = $urandom; end
         1: begin t.wrt = 1'b1; t.rd = 1'b1; t.sel = 1'b1; t.alu = a; end
         2: begin t.wr = 1'b1; t.alu = a; end
         3: begin t.br = 1'b1; t.taken = 1'($urandom_range(0, 1)); t.alu = 32'($urandom_range(0, 255)) << 2; end
         default: begin
            t.jump = 1'b1; t.link = 1'($urandom_range(0, 1)); t.wrt = t.link;
            t.alu = 32'($urandom_range(0, 255)) << 2;
         end
      endcase
      return t;
   endfunction

   // Runs one instruction through the DUT; returns with trap reported through m_cause
   task automatic exec(input instr_t t);
      logic        mem, mis;
      logic [31:0] exp_wb;
      dec_wrt_en       = t.wrt;
      dec_mem_rd_en    = t.rd;
      dec_mem_wrt_en   = t.wr;
      dec_wrt_back_sel = t.sel;
      dec_branch_en    = t.br;
      dec_jump         = t.jump;
      dec_link         = t.link;
      dec_illegal      = t.ill;
      dec_mem_mask     = t.mask;
      alu_out          = t.alu;
      branch_taken     = t.taken;
      dmem_ready       = 1'b0;

      if (m_pc[1:0] != 2'b00) begin
         imem_ready = 1'b0;
         #1;
         chk1("fmis_no_req", imem_req, 1'b0);
         nxt(); m_cycle++;
         m_cause = 2'd1;
         chk1 ("fmis_trap", trap, 1'b1);
         chk2 ("fmis_cause", trap_cause, 2'd1);
         chk32("fmis_pc", pc, m_pc);
         chk64("fmis_cycle", cycle_cnt, m_cycle);
         return;
      end

      for (int k = 0; k <= t.wi; k++) begin
         imem_ready = (k == t.wi);
         imem_rdata = (k == t.wi) ? t.word : ~t.word;
         #1;
         chk1 ("fetch_req", imem_req, 1'b1);
         chk32("fetch_addr", imem_addr, m_pc);
         chk32("fetch_ir_hold", ir, m_ir);
         chk1 ("fetch_no_dreq", dmem_req, 1'b0);
         nxt(); m_cycle++;
      end
      imem_ready = 1'b0;
      m_ir = t.word;

      chk32("decode_ir", ir, m_ir);
      chk1 ("decode_no_req", imem_req, 1'b0);
      nxt(); m_cycle++;
      if (t.ill) begin
         m_cause = 2'd3;
         chk1 ("ill_trap", trap, 1'b1);
         chk2 ("ill_cause", trap_cause, 2'd3);
         chk64("ill_cycle", cycle_cnt, m_cycle);
         return;
      end

      chk1("exec_no_trap", trap, 1'b0);
      nxt(); m_cycle++;
      mem = t.rd | t.wr;
      mis = (t.mask == 2'd1) ? t.alu[0] : (t.mask == 2'd0) ? 1'b0 : (t.alu[1:0] != 2'b00);
      if (mem && mis) begin
         m_cause = 2'd2;
         chk1 ("ldst_trap", trap, 1'b1);
         chk2 ("ldst_cause", trap_cause, 2'd2);
         chk1 ("ldst_no_dreq", dmem_req, 1'b0);
         chk64("ldst_cycle", cycle_cnt, m_cycle);
         return;
      end

      if (mem) begin
         for (int k = 0; k <= t.wd; k++) begin
            dmem_ready = (k == t.wd) && (t.rst_at < 0);
            dmem_rdata = (k == t.wd) ? t.rdata : ~t.rdata;
            #1;
            chk1 ("mem_req", dmem_req, 1'b1);
            chk32("mem_addr", dmem_addr, t.alu);
            chk1 ("mem_we", dmem_we, t.wr);
            chk2 ("mem_mask", dmem_mask, t.mask);
            if (t.rst_at == k) begin
               rst = 1'b0;
               #1;
               check_reset_state();
               nxt();
               rst = 1'b1;
               model_reset();
               return;
            end
            nxt(); m_cycle++;
         end
         dmem_ready = 1'b0;
         if (t.rd) m_mdr = t.rdata;
      end

      exp_wb = t.link ? m_pc + 32'd4 : t.sel ? m_mdr : t.alu;
      #1;
      chk1("wb_strobe", rf_wrt_en, t.wrt);
      if (t.wrt) chk32("wb_data", wb_data, exp_wb);
      chk1("wb_no_dreq", dmem_req, 1'b0);
      nxt(); m_cycle++; m_instret++;
      m_pc = (t.jump || (t.br && t.taken)) ? t.alu : m_pc + 32'd4;
      chk32("next_pc", pc, m_pc);
      chk64("instret", instret_cnt, m_instret);
      chk64("cycle", cycle_cnt, m_cycle);
      chk1 ("post_wb_strobe", rf_wrt_en, 1'b0);
      chk1 ("no_trap", trap, 1'b0);
   endtask

   task automatic check_frozen(input int n);
      for (int i = 0; i < n; i++) begin
         nxt();
         chk1 ("frz_trap", trap, 1'b1);
         chk2 ("frz_cause", trap_cause, m_cause);
         chk32("frz_pc", pc, m_pc);
         chk64("frz_cycle", cycle_cnt, m_cycle);
         chk64("frz_instret", instret_cnt, m_instret);
         chk1 ("frz_ireq", imem_req, 1'b0);
         chk1 ("frz_dreq", dmem_req, 1'b0);
         chk1 ("frz_rf", rf_wrt_en, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t t;
      rst = 1'b0;
      imem_ready = 1'b0; imem_rdata = 32'h0;
      dmem_ready = 1'b0; dmem_rdata = 32'h0;
      dec_wrt_en = 1'b0; dec_mem_rd_en = 1'b0; dec_mem_wrt_en = 1'b0; dec_wrt_back_sel = 1'b0;
      dec_branch_en = 1'b0; dec_jump = 1'b0; dec_link = 1'b0; dec_illegal = 1'b0;
      dec_mem_mask = 2'd0; alu_out = 32'h0; branch_taken = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // addi from reset vector, zero-wait
      t = base_instr(); t.wrt = 1'b1; t.alu = 32'h0000_0007; t.word = 32'h0070_0093;
      exec(t);
      chk64("addi_cycles", cycle_cnt, 64'd4);
      chk32("addi_pc", pc, 32'h0000_0104);

      // load word with three wait cycles
      t = base_instr(); t.wrt = 1'b1; t.rd = 1'b1; t.sel = 1'b1; t.alu = 32'h20;
      t.rdata = 32'hDEAD_BEEF; t.wd = 3;
      exec(t);
      chk64("load_cycles", cycle_cnt, 64'd12);

      // taken branch, then not-taken branch
      t = base_instr(); t.br = 1'b1; t.taken = 1'b1; t.alu = 32'h40;
      exec(t);
      chk32("br_taken_fetch", imem_addr, 32'h40);
      t = base_instr(); t.br = 1'b1; t.taken = 1'b0; t.alu = 32'h200;
      exec(t);
      chk32("br_not_taken_pc", pc, 32'h44);

      // jump to 0x10, then jal to 0x80 with link
      t = base_instr(); t.jump = 1'b1; t.alu = 32'h10;
      exec(t);
      t = base_instr(); t.jump = 1'b1; t.link = 1'b1; t.wrt = 1'b1; t.alu = 32'h80;
      exec(t);

      // pc wraps at the top of the address space
      t = base_instr(); t.jump = 1'b1; t.alu = 32'hFFFF_FFFC;
      exec(t);
      t = base_instr(); t.wrt = 1'b1; t.alu = 32'h1234_5678;
      exec(t);
      chk32("pc_wrap", pc, 32'h0);

      for (int i = 0; i < 40; i++) begin
         t = rnd_instr();
         exec(t);
      end

      // reset asserted during a load wait state
      t = base_instr(); t.wrt = 1'b1; t.rd = 1'b1; t.sel = 1'b1; t.alu = 32'h300;
      t.wd = 3; t.rst_at = 1;
      exec(t);
      t = base_instr(); t.wrt = 1'b1; t.alu = 32'h55; t.wi = 2;
      exec(t);
      chk32("post_rst_pc", pc, 32'h104);

      // misaligned half store
      t = base_instr(); t.wr = 1'b1; t.mask = 2'd1; t.alu = 32'h21;
      exec(t);
      check_frozen(4);

      do_reset();
      t = base_instr(); t.ill = 1'b1; t.wrt = 1'b1;
      exec(t);
      check_frozen(3);

      do_reset();
      t = base_instr(); t.jump = 1'b1; t.alu = 32'h82;
      exec(t);
      t = base_instr(); t.wrt = 1'b1;
      exec(t);
      check_frozen(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mc_core_ctrl.md
# mc_core_ctrl

Multi-cycle sequencing controller for the RV32I core, replacing single-cycle "everything in one clock" execution. It drives the existing decode, register, ALU and branch datapath through FETCH/DECODE/EXEC/MEM/WB states. Instruction and data memories sit behind valid/ready handshakes, so variable-latency memories can be attached. It owns the PC, instruction register, write-back mux, alignment/illegal-instruction traps and cycle/instret counters.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- XLEN, 32, address/data width
- CNT_W, 64, width of cycle and instret counters

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- imem_req  out  1  instruction fetch request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- ir  out  32  instruction register, feeds decoder
- dec_wrt_en, dec_mem_rd_en, dec_mem_wrt_en, dec_wrt_back_sel, dec_branch_en, dec_jump, dec_link, dec_illegal  in  1 each  decoded controls
- dec_mem_mask  in  2  0 byte, 1 half, 2 word
- alu_out  in  XLEN  ALU result (address / branch target / result)
- branch_taken  in  1  branch comparator result
- dmem_req  out  1  data access request
- dmem_we  out  1  1 store, 0 load
- dmem_addr  out  XLEN  data address
- dmem_mask  out  2  access size
- dmem_ready  in  1  access complete; load data valid
- dmem_rdata  in  XLEN  load data
- rf_wrt_en  out  1  register-file write strobe
- wb_data  out  XLEN  register-file write data
- pc  out  XLEN  current PC
- trap  out  1  sticky halt flag
- trap_cause  out  2  0 none, 1 fetch misaligned, 2 load/store misaligned, 3 illegal
- cycle_cnt, instret_cnt  out  CNT_W each  performance counters

## Operation
- Reset (rst=0): state FETCH, pc=RESET_PC, ir=32'h0000_0013, alu_q=0, mdr=0, trap=0, trap_cause=0, counters 0. All req/strobe outputs 0 asynchronously.
- FETCH: if pc[1:0]!=0, go to TRAP with cause 1 and no request. Otherwise hold imem_req=1 with imem_addr=pc stable. On imem_ready=1, ir<=imem_rdata and go to DECODE.
- DECODE: one cycle for register read. If dec_illegal, go to TRAP with cause 3; else go to EXEC.
- EXEC: alu_q<=alu_out.
  - If dec_mem_rd_en|dec_mem_wrt_en, check alignment: half requires alu_out[0]=0, word requires alu_out[1:0]=0. Failure goes to TRAP with cause 2; pass goes to MEM.
  - Otherwise go to WB.
- MEM: dmem_req=1; dmem_addr=alu_q, dmem_we=dec_mem_wrt_en and dmem_mask are held stable until dmem_ready. On dmem_ready, mdr<=dmem_rdata if load, then go to WB.
- WB: rf_wrt_en=dec_wrt_en for exactly one cycle.
  - wb_data = dec_link ? pc+4 : dec_wrt_back_sel ? mdr : alu_q.
  - pc <= (dec_jump | (dec_branch_en & branch_taken)) ? alu_q : pc+4.
  - instret_cnt increments; next state is FETCH.
- TRAP: terminal. trap=1 and cause hold. No requests, no register writes, pc frozen. Only rst exits.
- Stores never assert rf_wrt_en unless dec_wrt_en is set (the decoder guarantees it is clear).
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 = 0. Counters wrap modulo 2^CNT_W.

## Timing
- Zero-wait memories (ready in the request cycle): ALU/branch/jump takes 4 cycles (F,D,E,W); load/store takes 5.
- Each wait cycle on imem_ready or dmem_ready adds one cycle. The request stays asserted and its address is unchanged.
- ir changes only on the FETCH handshake cycle. pc changes only at the end of WB or on reset.
- cycle_cnt increments every cycle outside TRAP, including wait cycles. It does not increment in TRAP.
- Reset asserted mid-MEM or mid-FETCH drops the request immediately. The memory must tolerate an abandoned request.
- Trap entry is at the edge ending the detecting state (FETCH/DECODE/EXEC). trap is visible the next cycle.

## Test plan
- Reset with RESET_PC=32'h100, imem zero-wait returning addi: imem_addr=0x100, rf_wrt_en on cycle 4, pc=0x104 after cycle 4, instret_cnt=1, cycle_cnt=4.
- Load word at alu_out=0x20, dmem_ready delayed 3 cycles, dmem_rdata=0xDEADBEEF: dmem_addr/mask stable 4 cycles, wb_data=0xDEADBEEF with rf_wrt_en on cycle 8.
- Taken branch (dec_branch_en=1, branch_taken=1, alu_out=0x40): next imem_addr=0x40. Not-taken: pc+4, rf_wrt_en=0.
- Jump with dec_link=1 at pc=0x10, target 0x80: wb_data=0x14, pc=0x80.
- Half store at alu_out=0x21: no dmem_req, trap=1 with cause 2. Illegal decode gives cause 3. Jump to 0x82 gives cause 1 on the next fetch. cycle_cnt frozen afterward.
- rst low during MEM wait: dmem_req drops in the same cycle, pc=RESET_PC and counters 0. Fetch resumes after release.
